// File: rtl/serial_adder.sv
// Bit-serial adder: operands are shifted LSB first through a single full adder,
// producing {cout,sum} = a + b after WIDTH add cycles and a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [1:0]       ha_lo;
  logic [1:0]       ha_hi;
  logic             bit_s;
  logic             carry_next;
  logic             last_bit;

  // Returns {carry, sum} of a single half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder built from two cascaded half adders plus an OR on the carries.
  always_comb begin
    ha_lo      = half_add(a_sh[0], b_sh[0]);
    ha_hi      = half_add(ha_lo[0], carry);
    bit_s      = ha_hi[0];
    carry_next = ha_lo[1] | ha_hi[1];
    last_bit   = (cnt == LAST);
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (start) state_next = ADD;
        else       state_next = IDLE;
      end
      ADD: begin
        if (last_bit) state_next = DONE;
        else          state_next = ADD;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ADD);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: operand capture, per-bit shift/accumulate, result load on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end else begin
            a_sh  <= a_sh;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          psum  <= {bit_s, psum[WIDTH-1:1]};
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= {bit_s, psum[WIDTH-1:1]};
            cout <= carry_next;
          end else begin
            sum  <= sum;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8): reset, adder corners,
// start-ignore, asynchronous abort and back-to-back operation.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; lat = edges until done seen (-1 on timeout).
  task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                       output logic [7:0] r_sum, output logic r_cout,
                       output int lat, output int busy_cycles);
    start = 1'b1; a = op_a; b = op_b;
    lat = -1; busy_cycles = 0; r_sum = 8'hxx; r_cout = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      step();
      start = 1'b0; a = ~op_a; b = ~op_b;
      if (busy) busy_cycles++;
      if (done) begin
        lat = k; r_sum = sum; r_cout = cout;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'h000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
    end
    start = 1'b1; a = 8'h55; b = 8'h55;
    step(); step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_holds_start: got busy=%b done=%b expected 0 0", busy, done);
    end
    start = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_half_adder();
    logic [7:0] ta [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
    logic [7:0] tb [4] = '{8'h00, 8'h00, 8'h01, 8'h01};
    logic [7:0] es [4] = '{8'h00, 8'h01, 8'h01, 8'h02};
    logic [7:0] rs;
    logic       rc;
    int         lat;
    int         bc;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], rs, rc, lat, bc);
      checks += 3;
      if (rs !== es[i]) begin
        errors++;
        $display("FAIL ha_sum[%0d]: got %h expected %h", i, rs, es[i]);
      end
      if (rc !== 1'b0) begin
        errors++;
        $display("FAIL ha_cout[%0d]: got %b expected 0", i, rc);
      end
      if (lat != 9) begin
        errors++;
        $display("FAIL ha_latency[%0d]: got %0d expected 9", i, lat);
      end
    end
  endtask

  task automatic test_carry();
    logic [7:0] ta [2] = '{8'hFF, 8'hFF};
    logic [7:0] tb [2] = '{8'h01, 8'hFF};
    logic [7:0] es [2] = '{8'h00, 8'hFE};
    logic [7:0] rs;
    logic       rc;
    int         lat;
    int         bc;
    for (int i = 0; i < 2; i++) begin
      do_op(ta[i], tb[i], rs, rc, lat, bc);
      checks += 2;
      if (rs !== es[i]) begin
        errors++;
        $display("FAIL carry_sum[%0d]: got %h expected %h", i, rs, es[i]);
      end
      if (rc !== 1'b1) begin
        errors++;
        $display("FAIL carry_cout[%0d]: got %b expected 1", i, rc);
      end
    end
  endtask

  // Previous result is FE/1; it must hold through ADD until the completion edge.
  task automatic test_alternating();
    int  bc = 0;
    bit  seen = 0;
    start = 1'b1; a = 8'hA5; b = 8'h5A;
    for (int k = 1; k <= 30 && !seen; k++) begin
      step();
      start = 1'b0; a = 8'h00; b = 8'h00;
      if (busy) begin
        bc++;
        checks++;
        if (sum !== 8'hFE || cout !== 1'b1) begin
          errors++;
          $display("FAIL alt_hold: got sum=%h cout=%b expected FE 1 during ADD", sum, cout);
        end
      end
      if (done) begin
        seen = 1;
        checks += 2;
        if (sum !== 8'hFF || cout !== 1'b0) begin
          errors++;
          $display("FAIL alt_result: got sum=%h cout=%b expected FF 0", sum, cout);
        end
        if (bc != 8) begin
          errors++;
          $display("FAIL alt_busy_len: got %0d expected 8", bc);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL alt_timeout: got no done expected done");
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL alt_done_width: got done=%b expected 0", done);
    end
  endtask

  task automatic test_start_ignored();
    int         dcnt = 0;
    logic [7:0] rs = 8'hxx;
    logic       rc = 1'bx;
    start = 1'b1; a = 8'h10; b = 8'h20;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; a = 8'h77; b = 8'h77;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) begin
        dcnt++; rs = sum; rc = cout;
      end
    end
    checks += 3;
    if (dcnt != 1) begin
      errors++;
      $display("FAIL ign_done_count: got %0d expected 1", dcnt);
    end
    if (rs !== 8'h30 || rc !== 1'b0) begin
      errors++;
      $display("FAIL ign_result: got sum=%h cout=%b expected 30 0", rs, rc);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_restart: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int         dcnt = 0;
    logic [7:0] rs;
    logic       rc;
    int         lat;
    int         bc;
    start = 1'b1; a = 8'h80; b = 8'h80;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 11'h000) begin
      errors++;
      $display("FAIL rst_mid_now: got busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
    end
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done) dcnt++;
    end
    checks++;
    if (dcnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done: got done_count=%0d busy=%b expected 0 0", dcnt, busy);
    end
    do_op(8'h80, 8'h80, rs, rc, lat, bc);
    checks += 2;
    if (rs !== 8'h00 || rc !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rerun: got sum=%h cout=%b expected 00 1", rs, rc);
    end
    if (lat != 9) begin
      errors++;
      $display("FAIL rst_mid_latency: got %0d expected 9", lat);
    end
  endtask

  task automatic test_back_to_back();
    int dcnt = 0;
    int last_k = 0;
    start = 1'b1; a = 8'h03; b = 8'h04;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (done) begin
        dcnt++;
        checks += 2;
        if (sum !== 8'h07 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result: got sum=%h cout=%b expected 07 0", sum, cout);
        end
        if (k - last_k != ((dcnt == 1) ? 9 : 10)) begin
          errors++;
          $display("FAIL b2b_interval: got %0d expected %0d", k - last_k, (dcnt == 1) ? 9 : 10);
        end
        last_k = k;
      end
    end
    start = 1'b0;
    checks++;
    if (dcnt != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 3", dcnt);
    end
  endtask

  initial begin
    test_reset();
    test_half_adder();
    test_carry();
    test_alternating();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 SHALL have port: busy  output  1  high while in ADD state.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port: sum  output  WIDTH  registered result, held until next completion.
REQ-010 SHALL have port: cout  output  1  registered final carry, held with sum.

Function
REQ-011 SHALL implement FSM with states IDLE, ADD, DONE only; any unused encoding SHALL return to IDLE on next edge.
REQ-012 SHALL, in IDLE with start=1 at an edge: load a and b into shift registers, clear carry flop to 0, clear bit counter to 0, and go to ADD.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE with all registers unchanged.
REQ-014 SHALL, on each ADD edge, form bit sum s = a_sh[0] ^ b_sh[0] ^ c and carry c' = (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0])), i.e. two cascaded half adders plus OR.
REQ-015 SHALL, on each ADD edge, shift a_sh and b_sh right by one, shift s into the MSB of the partial-sum register, update the carry flop with c', and increment the counter.
REQ-016 SHALL process operands LSB first, exactly WIDTH ADD edges per operation, counter width ceil(log2(WIDTH))+1 with no wrap inside an operation.
REQ-017 SHALL, on the ADD edge where the counter reaches WIDTH-1, load sum with the completed partial-sum (including that edge's bit) and cout with that edge's c', and go to DONE.
REQ-018 SHALL assert done for exactly the one cycle spent in DONE, then go to IDLE on the next edge regardless of start.
REQ-019 SHALL produce done high WIDTH+1 edges after the edge that accepted start (latency WIDTH+1 cycles, i.e. 9 for WIDTH=8).
REQ-020 SHALL ignore start while busy or in DONE; no re-capture of a, b, no restart, no effect on the running result.
REQ-021 SHALL permit back-to-back operations: start high during DONE is ignored; start high in the following IDLE cycle is accepted.
REQ-022 SHALL keep sum and cout unchanged during ADD; they change only on the ADD-to-DONE edge.
REQ-023 SHALL compute {cout,sum} = a + b modulo 2^(WIDTH+1) exactly, including all-ones wrap-around.
REQ-024 SHALL hold a and b changes after acceptance as don't-care for the running operation.

Reset
REQ-025 SHALL, on rst=1, immediately (without clock) force state IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, shift registers=0.
REQ-026 SHALL abort any operation in progress when rst asserts mid-ADD; no done pulse follows and sum/cout read 0.
REQ-027 SHALL, while rst is held high, ignore start; first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL cover half-adder corners (WIDTH=8): a=0,b=0 -> sum=0x00,cout=0; a=1,b=0 -> 0x01,0; a=0,b=1 -> 0x01,0; a=1,b=1 -> 0x02,0; each with done exactly 9 cycles after start.
REQ-029 SHALL cover carry ripple/wrap: a=0xFF,b=0x01 -> sum=0x00,cout=1; a=0xFF,b=0xFF -> sum=0xFE,cout=1.
REQ-030 SHALL cover no-carry alternating: a=0xA5,b=0x5A -> sum=0xFF,cout=0, busy high for exactly 8 cycles.
REQ-031 SHALL cover start ignored: start a=0x10,b=0x20, pulse start with a=0x77,b=0x77 at cycle 3 of ADD -> result 0x30,cout=0, single done pulse.
REQ-032 SHALL cover reset mid-operation: start a=0x80,b=0x80, assert rst asynchronously between edges at cycle 4 -> busy=0,done=0,sum=0,cout=0 immediately; no done afterward; new start after release with a=0x80,b=0x80 -> sum=0x00,cout=1.
REQ-033 SHALL cover back-to-back: start held high continuously with a=3,b=4 -> done pulses every 10 cycles, sum=0x07 each time.
